// File: rtl/disp_pkg.sv
// Shared widths, limits and FSM encoding for the BCD scan driver.
// Also holds the input clamp, which is used when a value is captured.
package disp_pkg;

    localparam int DIGITS  = 4;
    localparam int BCD_W   = 4;
    localparam int BIN_W   = 14;
    localparam int DISP_W  = DIGITS * BCD_W;
    localparam int SHIFT_W = DISP_W + BIN_W;

    localparam logic [BIN_W-1:0] MAX_VAL = 14'd9999;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    typedef struct packed {
        logic             ovf;
        logic [BIN_W-1:0] val;
    } clamp_t;

    function automatic clamp_t clamp_value(input logic [BIN_W-1:0] v);
        clamp_t r;
        r.ovf = (v > MAX_VAL);
        r.val = r.ovf ? MAX_VAL : v;
        return r;
    endfunction

endpackage

// File: rtl/disp_bcd_scan_driver_if.sv
// Load/value inputs and scan/status outputs between the upstream logic
// and the BCD scan driver.
interface disp_bcd_scan_driver_if;
    import disp_pkg::*;

    logic [BIN_W-1:0] value_in;
    logic             load;
    logic [1:0]       scan_idx;
    logic [BCD_W-1:0] digit_bcd;
    logic             digit_blank;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output value_in, load,
        input  scan_idx, digit_bcd, digit_blank, busy, done, overflow
    );

    modport slave (
        input  value_in, load,
        output scan_idx, digit_bcd, digit_blank, busy, done, overflow
    );

endinterface

// File: rtl/bcd_adj3.sv
// Double-dabble nibble correction: any BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_adj3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/disp_bcd_scan_driver.sv
// Binary-to-BCD front end for a 4-digit multiplexed 7-segment display:
// sequential double-dabble conversion, tear-free display register, digit scan.
module disp_bcd_scan_driver
    import disp_pkg::*;
#(
    parameter int PRESCALE    = 50000,
    parameter bit LZ_SUPPRESS = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    disp_bcd_scan_driver_if.slave  bus
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    state_t             state_q, state_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               conv_ovf_q, conv_ovf_d;
    logic [BIN_W-1:0]   pend_val_q, pend_val_d;
    logic               pend_ovf_q, pend_ovf_d;
    logic               pend_vld_q, pend_vld_d;
    logic [DISP_W-1:0]  disp_q, disp_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [1:0]         scan_q, scan_d;

    clamp_t             in_c;
    logic [DISP_W-1:0]  adj;
    logic [SHIFT_W-1:0] adj_full;
    logic [DIGITS-1:0]  upper_zero;

    assign in_c = clamp_value(bus.value_in);

    // Correct every BCD nibble in parallel, then the whole register shifts once.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_adj3 u_adj (
                .din  (shift_q[BIN_W + BCD_W*gi +: BCD_W]),
                .dout (adj[BCD_W*gi +: BCD_W])
            );
            assign upper_zero[gi] = (disp_q[DISP_W-1 : BCD_W*gi] == '0);
        end
    endgenerate

    assign adj_full = {adj, shift_q[BIN_W-1:0]};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        conv_ovf_d = conv_ovf_q;
        pend_val_d = pend_val_q;
        pend_ovf_d = pend_ovf_q;
        pend_vld_d = pend_vld_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    shift_d    = {{DISP_W{1'b0}}, in_c.val};
                    conv_ovf_d = in_c.ovf;
                    bit_cnt_d  = 4'd0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                shift_d   = adj_full << 1;
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'(BIN_W - 1)) begin
                    state_d = COMMIT;
                end
                if (bus.load) begin
                    pend_vld_d = 1'b1;
                    pend_val_d = in_c.val;
                    pend_ovf_d = in_c.ovf;
                end
            end
            COMMIT: begin
                disp_d = shift_q[SHIFT_W-1:BIN_W];
                ovf_d  = conv_ovf_q;
                done_d = 1'b1;
                // A load on this very edge is the newest pending value.
                if (bus.load || pend_vld_q) begin
                    shift_d    = {{DISP_W{1'b0}}, (bus.load ? in_c.val : pend_val_q)};
                    conv_ovf_d = bus.load ? in_c.ovf : pend_ovf_q;
                    bit_cnt_d  = 4'd0;
                    pend_vld_d = 1'b0;
                    state_d    = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);

        if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            scan_d = scan_q + 2'd1;
        end else begin
            pre_d  = pre_q + PRE_W'(1);
            scan_d = scan_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            conv_ovf_q <= 1'b0;
            pend_val_q <= '0;
            pend_ovf_q <= 1'b0;
            pend_vld_q <= 1'b0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pre_q      <= '0;
            scan_q     <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            conv_ovf_q <= conv_ovf_d;
            pend_val_q <= pend_val_d;
            pend_ovf_q <= pend_ovf_d;
            pend_vld_q <= pend_vld_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pre_q      <= pre_d;
            scan_q     <= scan_d;
        end
    end

    assign bus.scan_idx    = scan_q;
    assign bus.digit_bcd   = disp_q[BCD_W*scan_q +: BCD_W];
    assign bus.digit_blank = LZ_SUPPRESS && (scan_q != 2'd0) && upper_zero[scan_q];
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_disp_bcd_scan_driver.sv
// Scoreboard bench for disp_bcd_scan_driver: two instances (with and without
// leading-zero blanking) driven identically, checked every cycle.
module tb_disp_bcd_scan_driver;
    import disp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    disp_bcd_scan_driver_if bus_a ();
    disp_bcd_scan_driver_if bus_b ();

    disp_bcd_scan_driver #(.PRESCALE(4), .LZ_SUPPRESS(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    disp_bcd_scan_driver #(.PRESCALE(4), .LZ_SUPPRESS(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct {
        logic [15:0] disp;
        logic        ovf;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] exp_disp = '0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          load_cyc = 0;
    int          done_cnt = 0;
    bit          lat_check = 1'b0;
    logic [1:0]  m_idx;
    int          m_pre;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        int c;
        c = (v > 9999) ? 9999 : v;
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic logic exp_blank(input logic [15:0] d, input logic [1:0] idx);
        if (idx == 2'd0) return 1'b0;
        for (int k = int'(idx); k < 4; k++) begin
            if (d[4*k +: 4] != 4'd0) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference scan counter: 4 clocks per digit slot.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pre <= 0;
            m_idx <= 2'd0;
        end else if (m_pre == 3) begin
            m_pre <= 0;
            m_idx <= m_idx + 2'd1;
        end else begin
            m_pre <= m_pre + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_a.done) begin
                done_cnt++;
                check_val("done_b", 32'(bus_b.done), 32'd1);
                if (sb_q.size() == 0) begin
                    check_val("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    exp_disp = e.disp;
                    check_val("overflow", 32'(bus_a.overflow), 32'(e.ovf));
                    check_val("overflow_b", 32'(bus_b.overflow), 32'(e.ovf));
                    check_val("busy_at_done", 32'(bus_a.busy), 32'(sb_q.size() != 0));
                    if (lat_check) check_val("latency", 32'(cyc - load_cyc), 32'd16);
                end
            end
            check_val("scan_idx", 32'(bus_a.scan_idx), 32'(m_idx));
            check_val("scan_idx_b", 32'(bus_b.scan_idx), 32'(m_idx));
            check_val("digit", 32'(bus_a.digit_bcd), 32'(exp_disp[4*m_idx +: 4]));
            check_val("blank", 32'(bus_a.digit_blank), 32'(exp_blank(exp_disp, m_idx)));
            check_val("digit_b", 32'(bus_b.digit_bcd), 32'(exp_disp[4*m_idx +: 4]));
            check_val("blank_b", 32'(bus_b.digit_blank), 32'd0);
        end
    end

    task automatic do_load(input int v, input bit commits);
        @(negedge clk);
        bus_a.value_in = 14'(v);
        bus_b.value_in = 14'(v);
        bus_a.load = 1'b1;
        bus_b.load = 1'b1;
        load_cyc = cyc;
        if (commits) sb_q.push_back('{disp: to_bcd(v), ovf: (v > 9999)});
        @(posedge clk);
        #1;
        bus_a.load = 1'b0;
        bus_b.load = 1'b0;
        check_val("busy_after_load", 32'(bus_a.busy), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (!bus_a.busy && sb_q.size() == 0) return;
        end
        check_val("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic sweep();
        repeat (16) @(negedge clk);
    endtask

    initial begin
        int d0;
        bus_a.value_in = '0;
        bus_b.value_in = '0;
        bus_a.load = 1'b0;
        bus_b.load = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(bus_a.busy), 32'd0);
        check_val("rst_done", 32'(bus_a.done), 32'd0);
        check_val("rst_ovf", 32'(bus_a.overflow), 32'd0);
        check_val("rst_scan", 32'(bus_a.scan_idx), 32'd0);
        check_val("rst_digit", 32'(bus_a.digit_bcd), 32'd0);
        check_val("rst_blank", 32'(bus_a.digit_blank), 32'd0);
        #2 rst = 1'b0;

        // Reset in the middle of a conversion abandons it.
        do_load(500, 1'b1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        sb_q.delete();
        exp_disp = '0;
        #1;
        check_val("midrst_busy", 32'(bus_a.busy), 32'd0);
        check_val("midrst_scan", 32'(bus_a.scan_idx), 32'd0);
        check_val("midrst_digit", 32'(bus_a.digit_bcd), 32'd0);
        check_val("midrst_done", 32'(bus_a.done), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        do_load(321, 1'b1);
        wait_idle();
        sweep();

        lat_check = 1'b1;
        do_load(1234, 1'b1);
        wait_idle();
        lat_check = 1'b0;
        sweep();

        do_load(16383, 1'b1);
        wait_idle();
        sweep();
        do_load(7, 1'b1);
        wait_idle();
        sweep();

        do_load(0, 1'b1);
        wait_idle();
        sweep();

        // Two loads while busy: only the last survives in the pending slot.
        d0 = done_cnt;
        do_load(100, 1'b1);
        repeat (3) @(negedge clk);
        do_load(42, 1'b0);
        repeat (2) @(negedge clk);
        do_load(58, 1'b1);
        wait_idle();
        check_val("pending_done_pulses", 32'(done_cnt - d0), 32'd2);
        sweep();

        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
